// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: owner states,
// DMType encodings understood by dm, and the default starvation limit.
package dm_arb_pkg;

  typedef enum logic {
    FREE = 1'b0,
    DBG  = 1'b1
  } owner_t;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/dm_arb_wait_cnt.sv
// Saturating count of consecutive cycles the debug master was denied;
// expired lets the debug master pre-empt the CPU.
module dm_arb_wait_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_req,
  input  logic d_gnt,
  output logic expired
);

  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;

  always_comb begin
    cnt_next = 4'd0;
    if (d_req && !d_gnt) begin
      cnt_next = (cnt_reg == 4'd15) ? cnt_reg : cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_reg <= 4'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign expired = (cnt_reg >= 4'(MAX_WAIT));

endmodule

// File: rtl/dm_arbiter.sv
// CPU/debug arbiter in front of the single data memory. CPU has priority,
// a wait counter guarantees debug progress; the ownership lock is built
// only when DM_ARB_LOCK_EN is defined.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int AW       = 30
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [2:0]    c_type,
  input  logic [31:0]   c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [2:0]    d_type,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  input  logic          d_lock,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [2:0]    m_type,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  owner_t      owner;
  logic        locked;
  logic        expired;
  logic        c_rvalid_reg;
  logic        d_rvalid_reg;
  logic [31:0] c_rdata_reg;
  logic [31:0] d_rdata_reg;

  dm_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .rstn   (rstn),
    .d_req  (d_req),
    .d_gnt  (d_gnt),
    .expired(expired)
  );

`ifdef DM_ARB_LOCK_EN
  owner_t owner_next;

  always_comb begin
    owner_next = owner;
    case (owner)
      FREE:    if (d_gnt && d_lock) owner_next = DBG;
      DBG:     if (!d_lock || !d_req) owner_next = FREE;
      default: owner_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      owner <= FREE;
    end else begin
      owner <= owner_next;
    end
  end
`else
  assign owner = FREE;
`endif

  // The lock only binds while the debug master keeps both lock and request
  // up, so the CPU regains the memory in the very cycle the lock drops.
  assign locked = (owner == DBG) && d_lock && d_req;

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rstn) begin
      if (locked)                d_gnt = 1'b1;
      else if (d_req && expired) d_gnt = 1'b1;
      else if (c_req)            c_gnt = 1'b1;
      else if (d_req)            d_gnt = 1'b1;
    end
  end

  assign c_stall = c_req && !c_gnt;

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_type  = 3'd0;
    m_wdata = 32'd0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_type  = c_type;
      m_wdata = c_wdata;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_type  = d_type;
      m_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      c_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      c_rdata_reg  <= 32'd0;
      d_rdata_reg  <= 32'd0;
    end else begin
      c_rvalid_reg <= c_gnt && !c_we;
      d_rvalid_reg <= d_gnt && !d_we;
      if (c_gnt && !c_we) c_rdata_reg <= m_rdata;
      if (d_gnt && !d_we) d_rdata_reg <= m_rdata;
    end
  end

  assign c_rvalid = c_rvalid_reg;
  assign d_rvalid = d_rvalid_reg;
  assign c_rdata  = c_rdata_reg;
  assign d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a small word memory model;
// lock expectations follow whether DM_ARB_LOCK_EN is defined.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rstn;
  logic          c_req, c_we, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [2:0]    c_type, d_type;
  logic [31:0]   c_wdata, d_wdata;
  logic          c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [31:0]   c_rdata, d_rdata;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_type;
  logic [31:0]   m_wdata, m_rdata;

  logic [31:0] mem [0:63];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_WAIT(4), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_type(c_type), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_type(d_type), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_lock(d_lock),
    .m_we(m_we), .m_addr(m_addr), .m_type(m_type), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory model: combinational read, write at the clock edge.
  assign m_rdata = mem[m_addr[5:0]];
  always @(posedge clk) if (m_we) mem[m_addr[5:0]] <= m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic exp_d;
    int   widx;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    rstn = 1'b0; d_lock = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 30'h5; c_type = DM_WORD; c_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h6; d_type = DM_WORD; d_wdata = 32'hCAFE_F00D;

    // Reset: no grants and no write regardless of requests
    settle();
    $display("txn reset with requests");
    chk("rst_c_gnt", 32'(c_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    tick(); tick();
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem5", mem[5], 32'hA000_0005);

    // Idle
    rstn = 1'b1; c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
    settle();
    $display("txn idle");
    chk("idle_m_we", 32'(m_we), 32'd0);
    chk("idle_m_addr", 32'(m_addr), 32'd0);
    chk("idle_gnts", {30'd0, c_gnt, d_gnt}, 32'd0);
    tick();
    chk("idle_rvalids", {30'd0, c_rvalid, d_rvalid}, 32'd0);

    // CPU only: write then read back word 0x10
    c_req = 1'b1; c_we = 1'b1; c_addr = 30'h10; c_wdata = 32'h1234_5678;
    settle();
    $display("txn cpu write 0x10");
    chk("cw_c_gnt", 32'(c_gnt), 32'd1);
    chk("cw_c_stall", 32'(c_stall), 32'd0);
    chk("cw_m_we", 32'(m_we), 32'd1);
    chk("cw_m_addr", 32'(m_addr), 32'h10);
    chk("cw_m_wdata", m_wdata, 32'h1234_5678);
    tick();
    chk("cw_no_rvalid", 32'(c_rvalid), 32'd0);
    c_we = 1'b0;
    settle();
    $display("txn cpu read 0x10");
    chk("cr_c_gnt", 32'(c_gnt), 32'd1);
    chk("cr_c_stall", 32'(c_stall), 32'd0);
    chk("cr_m_we", 32'(m_we), 32'd0);
    tick();
    c_req = 1'b0;
    chk("cr_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("cr_c_rdata", c_rdata, 32'h1234_5678);
    chk("cr_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    chk("cr_rvalid_pulse", 32'(c_rvalid), 32'd0);

    // Debug only: back-to-back reads of words 0..3
    for (int i = 0; i < 4; i++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = AW'(i);
      settle();
      $display("txn debug read word %0d", i);
      chk("dr_d_gnt", 32'(d_gnt), 32'd1);
      chk("dr_d_rvalid", 32'(d_rvalid), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("dr_d_rdata", d_rdata, 32'hA000_0000 + 32'(i - 1));
      tick();
    end
    d_req = 1'b0;
    chk("dr_last_rvalid", 32'(d_rvalid), 32'd1);
    chk("dr_last_rdata", d_rdata, 32'hA000_0003);
    tick();
    chk("dr_rvalid_end", 32'(d_rvalid), 32'd0);

    // Contention: CPU 4 cycles, debug the 5th, period 5
    c_req = 1'b1; c_we = 1'b0; c_addr = 30'h1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2;
    for (int k = 0; k < 10; k++) begin
      exp_d = ((k % 5) == 4);
      settle();
      $display("txn contention cycle %0d", k);
      chk("ct_c_gnt", 32'(c_gnt), exp_d ? 32'd0 : 32'd1);
      chk("ct_d_gnt", 32'(d_gnt), exp_d ? 32'd1 : 32'd0);
      chk("ct_c_stall", 32'(c_stall), exp_d ? 32'd1 : 32'd0);
      chk("ct_m_addr", 32'(m_addr), exp_d ? 32'h2 : 32'h1);
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // Lock: debug writes with d_lock while the CPU keeps requesting
    c_req = 1'b1; c_we = 1'b0; c_addr = 30'h1;
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1;
    widx = 0; d_addr = 30'h8; d_wdata = 32'hD000_0000;
    for (int k = 0; k < 7; k++) begin
`ifdef DM_ARB_LOCK_EN
      exp_d = (k >= 4);
`else
      exp_d = (k == 4);
`endif
      settle();
      $display("txn lock cycle %0d", k);
      chk("lk_d_gnt", 32'(d_gnt), exp_d ? 32'd1 : 32'd0);
      chk("lk_c_stall", 32'(c_stall), exp_d ? 32'd1 : 32'd0);
      tick();
      if (exp_d) begin
        widx++;
        d_addr = AW'(8 + widx);
        d_wdata = 32'hD000_0000 + 32'(widx);
      end
    end
    d_lock = 1'b0; d_req = 1'b0;
    settle();
    $display("txn lock release");
    chk("lk_rel_c_gnt", 32'(c_gnt), 32'd1);
    chk("lk_rel_c_stall", 32'(c_stall), 32'd0);
    tick();
    c_req = 1'b0;
    chk("lk_mem8", mem[8], 32'hD000_0000);
`ifdef DM_ARB_LOCK_EN
    chk("lk_mem10", mem[10], 32'hD000_0002);
`else
    chk("lk_mem9", mem[9], 32'hA000_0009);
`endif

    // Reset asserted during a locked debug read
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 30'h3;
    settle();
    $display("txn locked read before reset");
    chk("rr_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    rstn = 1'b0;
    settle();
    chk("rr_rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rr_rst_m_we", 32'(m_we), 32'd0);
    tick();
    rstn = 1'b1; d_req = 1'b0; d_lock = 1'b0;
    settle();
    $display("txn after mid-op reset");
    chk("rr_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rr_d_rdata", d_rdata, 32'd0);
    chk("rr_c_rdata", c_rdata, 32'd0);
    chk("rr_wait_cnt", 32'(dut.u_wait.cnt_reg), 32'd0);
    chk("rr_owner", 32'(dut.owner), 32'(FREE));
    chk("rr_m_we", 32'(m_we), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter that shares the single data memory (`dm`) between the CPU load/store port and a debug/loader master. Sits between `SCPU` and `U_DM` in the `xgriscv_sc` top, owns the memory-side write enable, address, type and write data, and returns registered read data to whichever master was granted. The CPU has priority. A wait counter guarantees the debug master a slot, and an optional lock holds ownership across multi-cycle debug sequences.

## Interface
Parameters:
- `MAX_WAIT`, 4: consecutive denied cycles after which the debug master wins over the CPU (range 1..15).
- `AW`, 30: word-address width (matches `dm_addr[31:2]`).

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `c_req` in 1: CPU request.
- `c_we` in 1: CPU write.
- `c_addr` in AW: CPU word address.
- `c_type` in 3: CPU DMType.
- `c_wdata` in 32: CPU store data.
- `c_gnt` out 1: CPU granted this cycle.
- `c_stall` out 1: `c_req & ~c_gnt`; freezes the CPU PC.
- `c_rvalid` out 1: CPU read data valid.
- `c_rdata` out 32: CPU read data.
- `d_req`, `d_we`, `d_addr`, `d_type`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: debug-master equivalents, with the same widths as the CPU ports.
- `d_lock` in 1: debug master holds ownership. Used only when the lock feature is compiled in.
- `m_we` out 1: to `dm.DMWr`.
- `m_addr` out AW: to `dm.addr`.
- `m_type` out 3: to `dm.DMType`.
- `m_wdata` out 32: to `dm.din`.
- `m_rdata` in 32: from `dm.dout`. The memory read is combinational.

## Operation
- Grant is combinational from the requests and the registered state. At most one of `c_gnt` and `d_gnt` is high in any cycle.
- Grant rule, evaluated in order:
  1. If `owner==DBG` (locked), only the debug master is granted.
  2. If `d_req` is high and `wait_cnt>=MAX_WAIT`, the debug master is granted.
  3. If `c_req` is high, the CPU is granted.
  4. If `d_req` is high, the debug master is granted.
- Memory-side outputs mux the granted master's `we`, `addr`, `type` and `wdata`.
- With no grant: `m_we=0`, and `m_addr`, `m_type`, `m_wdata` are all 0.
- `m_we` is asserted only for a granted request with `we=1`.
- `wait_cnt` (4 bits):
  - Increments, saturating at 15, when `d_req & ~d_gnt`.
  - Clears when `d_gnt`.
  - Clears when `d_req` is low.
- Read response: a granted read (`we=0`) captures `m_rdata` into that master's `rdata` register, and its `rvalid` is pulse-high the next cycle.
- Writes produce no response. A non-granted master's `rdata` holds its value.
- Lock state machine, states `FREE` and `DBG`:
  - `FREE` → `DBG` when `d_gnt & d_lock`.
  - `DBG` → `FREE` when `~d_lock | ~d_req`.
  - In `DBG`, the CPU is stalled even if `c_req` is high.
- A master must hold `req`, `we`, `addr`, `type` and `wdata` stable until it sees `gnt`.

## Timing
- Grant latency: same cycle as `req` when uncontested.
- Contested CPU: stalls for 1 cycle per debug win.
- Write commit: at the rising edge ending the grant cycle.
- Read data: `rvalid`/`rdata` at 1 cycle after grant. Back-to-back reads give a `rvalid` every cycle.
- Reset values: `c_rvalid=d_rvalid=0`, `c_rdata=d_rdata=0`, `wait_cnt=0`, lock state `FREE`.
- Grants during reset: both 0, and `m_we=0`, regardless of requests.
- Reset asserted mid-lock: returns to `FREE`. A pending `rvalid` is dropped.
- Simultaneous `c_req` and `d_req` with `wait_cnt==MAX_WAIT-1`: the CPU wins and the counter reaches `MAX_WAIT`. The debug master wins the next cycle.

## Configuration
- `DM_ARB_LOCK_EN` defined: `d_lock` and the `FREE`/`DBG` lock state machine are built.
- `DM_ARB_LOCK_EN` undefined:
  - `d_lock` is ignored and the state is constant `FREE`.
  - Arbitration is per-cycle only, with the CPU able to interleave between every debug access.

## Structure
- Package `dm_arb_pkg` holds:
  - the owner enum (`FREE`, `DBG`);
  - the DMType encodings shared with `dm` (word, half, half-unsigned, byte, byte-unsigned);
  - the default `MAX_WAIT`.
- One sub-module `dm_arb_wait_cnt`: the saturating starvation counter, with output `expired = cnt>=MAX_WAIT`.
- The grant mux and response registers stay in `dm_arbiter`.

## Test plan
- CPU only:
  - Stimulus: CPU write of `0x12345678` to word 0x10, then a read of word 0x10.
  - Required: `c_gnt` both cycles, `c_stall=0`, `c_rvalid` on the cycle after the read with `c_rdata=0x12345678`.
- Debug only:
  - Stimulus: debug reads of words 0..3 back-to-back.
  - Required: 4 consecutive `d_rvalid` pulses, one per cycle, starting 1 cycle after the first `d_gnt`.
- Contention, `MAX_WAIT=4`:
  - Stimulus: both masters request continuously.
  - Required: CPU granted for 4 cycles, debug on the 5th (CPU `c_stall=1` that cycle), repeating with period 5.
- Lock, with `DM_ARB_LOCK_EN` defined:
  - Stimulus: `d_lock=1` with 3 debug writes while `c_req=1`.
  - Required: `c_stall=1` for exactly those 3 cycles, and CPU granted on the cycle `d_lock` drops.
  - Without the macro: the same stimulus produces no extended CPU stall.
- Reset mid-operation:
  - Stimulus: `rstn=0` for one cycle during a locked read.
  - Required: next cycle `d_rvalid=0`, `rdata` registers 0, `wait_cnt` 0, state `FREE`, `m_we=0`.
- Idle:
  - Stimulus: no requests.
  - Required: `m_we=0`, `m_addr=0`, no grants, and both `rvalid` outputs stay 0.
